// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and bubble insertion, feeding the EX-stage ALU of a 5-stage MIPS pipeline.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    // decode stage
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [2:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        flush,
    // writeback sources for forwarding
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    // EX stage outputs
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_control,
    output logic [31:0] ex_write_data,
    output logic [4:0]  ex_dest,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        stall
);

    localparam logic [2:0] ALU_ADD = 3'b010;

    logic        valid_q,      valid_d;
    logic        reg_write_q,  reg_write_d;
    logic        mem_read_q,   mem_read_d;
    logic        mem_write_q,  mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        alu_src_q,    alu_src_d;
    logic [2:0]  alu_ctrl_q,   alu_ctrl_d;
    logic [4:0]  dest_q,       dest_d;
    logic [4:0]  rs_q,         rs_d;
    logic [4:0]  rt_q,         rt_d;
    logic [31:0] rs_data_q,    rs_data_d;
    logic [31:0] rt_data_q,    rt_data_d;
    logic [31:0] imm_q,        imm_d;

    logic        hazard;
    logic        bubble;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Forwarded value for a stored source index; MEM beats WB, r0 never forwards.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] stored,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_res,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_res
    );
        logic [31:0] r;
        r = stored;
        if (m_we && (m_rd != 5'd0) && (m_rd == idx)) begin
            r = m_res;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == idx)) begin
            r = w_res;
        end
        return r;
    endfunction

    // Load-use detection; depends only on ID inputs and EX registers. Flush overrides.
    always_comb begin
        hazard = valid_q && mem_read_q && (dest_q != 5'd0) && id_valid &&
                 ((dest_q == id_rs) || (dest_q == id_rt));
        stall  = hazard && !flush;
        bubble = flush || stall || !id_valid;
    end

    // Next EX register contents: either the decoded instruction or a clean bubble
    // (indices cleared too, so a bubble never picks up a forwarded value).
    always_comb begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        alu_ctrl_d   = ALU_ADD;
        dest_d       = 5'd0;
        rs_d         = 5'd0;
        rt_d         = 5'd0;
        rs_data_d    = 32'd0;
        rt_data_d    = 32'd0;
        imm_d        = 32'd0;
        if (!bubble) begin
            valid_d      = 1'b1;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            mem_to_reg_d = id_mem_to_reg;
            alu_src_d    = id_alu_src;
            alu_ctrl_d   = id_alu_control;
            dest_d       = id_reg_dst ? id_rd : id_rt;
            rs_d         = id_rs;
            rt_d         = id_rt;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            imm_d        = id_imm;
        end
    end

    // EX register bank; reset forces the bubble state immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= ALU_ADD;
            dest_q       <= 5'd0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            dest_q       <= dest_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
        end
    end

    // Operand forwarding and EX-stage outputs.
    always_comb begin
        fwd_rs = fwd_sel(rs_q, rs_data_q, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_result);
        fwd_rt = fwd_sel(rt_q, rt_data_q, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_result);
        alu_a         = fwd_rs;
        alu_b         = alu_src_q ? imm_q : fwd_rt;
        ex_write_data = fwd_rt;
        alu_control   = alu_ctrl_q;
        ex_dest       = dest_q;
        ex_valid      = valid_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_mem_to_reg = mem_to_reg_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] alu_a, alu_b, ex_write_data;
    logic [2:0]  alu_control;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_write_data(ex_write_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [2:0]  ctrl;
        logic        alu_src;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } ex_t;

    ex_t model;

    function automatic ex_t nop_ex();
        ex_t e;
        e      = '0;
        e.ctrl = 3'b010;
        return e;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0)                          return stored;
        if (mem_reg_write && mem_rd == idx)       return mem_result;
        if (wb_reg_write && wb_rd == idx)         return wb_result;
        return stored;
    endfunction

    function automatic logic m_stall();
        logic uses;
        uses = (model.dest == id_rs) || (model.dest == id_rt);
        return model.valid && model.mr && (model.dest != 5'd0) && id_valid && uses && !flush;
    endfunction

    function automatic logic [31:0] m_a();  return m_fwd(model.rs, model.rs_data); endfunction
    function automatic logic [31:0] m_wd(); return m_fwd(model.rt, model.rt_data); endfunction
    function automatic logic [31:0] m_b();  return model.alu_src ? model.imm : m_wd(); endfunction

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [2:0] ctrl, input logic src,
                            input logic dst, input logic rw, input logic mr, input logic mw,
                            input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_control = ctrl;
        id_alu_src = src; id_reg_dst = dst; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic drive_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                             input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        mem_reg_write = mw; mem_rd = mrd; mem_result = mres;
        wb_reg_write = ww; wb_rd = wrd; wb_result = wres;
    endtask

    // Advance one clock; the model admits the ID instruction unless it must be dropped.
    task automatic tick();
        ex_t nxt;
        nxt = nop_ex();
        if (rst_n && !(flush || m_stall() || !id_valid)) begin
            nxt.valid = 1'b1;       nxt.rs = id_rs;          nxt.rt = id_rt;
            nxt.dest  = id_reg_dst ? id_rd : id_rt;
            nxt.rs_data = id_rs_data; nxt.rt_data = id_rt_data; nxt.imm = id_imm;
            nxt.ctrl = id_alu_control; nxt.alu_src = id_alu_src;
            nxt.rw = id_reg_write; nxt.mr = id_mem_read; nxt.mw = id_mem_write;
            nxt.m2r = id_mem_to_reg;
        end
        @(posedge clk);
        model = nxt;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive_id(1'b1, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 32'h8, 3'b110,
                 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        // a dependent instruction in ID so stall would be high without reset
        drive_id(1'b1, 5'd11, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 3'b000,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %0b want 1", stall); end
        rst_n = 1'b0;
        model = nop_ex();
        #1;
        n_checks++;
        if ({alu_a, alu_b, ex_write_data} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: a=%h b=%h wd=%h want all 0", alu_a, alu_b, ex_write_data);
        end
        n_checks++;
        if (alu_control !== 3'b010 || ex_dest !== 5'd0) begin
            n_fail++; $display("FAIL reset_ctrl: alu_control=%b dest=%0d want 010/0", alu_control, ex_dest);
        end
        n_checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_bits: got %b want 000000",
                               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
            n_fail++; $display("FAIL capture_ops: a=%0d b=%0d want 5/7", alu_a, alu_b);
        end
        n_checks++;
        if (alu_control !== 3'b010 || ex_valid !== 1'b1 || ex_dest !== 5'd3) begin
            n_fail++; $display("FAIL capture_ctrl: ctrl=%b valid=%b dest=%0d want 010/1/3",
                               alu_control, ex_valid, ex_dest);
        end
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        drive_id(1'b1, 5'd3, 5'd8, 5'd12, 32'h33, 32'h88, 32'd0, 3'b000,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b010,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        #1;
        n_checks++;
        if (alu_a !== 32'h11) begin n_fail++; $display("FAIL fwd_mem_over_wb: got %h want 11", alu_a); end
        mem_reg_write = 1'b0;
        #1;
        n_checks++;
        if (alu_a !== 32'h22) begin n_fail++; $display("FAIL fwd_wb: got %h want 22", alu_a); end
        wb_reg_write = 1'b0;
        #1;
        n_checks++;
        if (alu_a !== 32'h33) begin n_fail++; $display("FAIL fwd_none: got %h want 33", alu_a); end
    endtask

    task automatic test_reg0_imm();
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h4321, 32'h1234, 32'hFFFFFFFC, 3'b010,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        drive_fwd(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
        #1;
        n_checks++;
        if (alu_b !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL r0_alu_b: got %h want fffffffc", alu_b); end
        n_checks++;
        if (ex_write_data !== 32'h1234 || alu_a !== 32'h4321) begin
            n_fail++; $display("FAIL r0_no_fwd: wd=%h a=%h want 1234/4321", ex_write_data, alu_a);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 32'h10, 3'b010,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   // lw r4, 16(r1)
        tick();
        @(negedge clk);
        drive_id(1'b1, 5'd4, 5'd2, 5'd6, 32'hBAD, 32'h7, 32'd0, 3'b110,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // sub r6, r4, r2
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || alu_control !== 3'b010 || ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL lu_bubble: valid=%b ctrl=%b rw=%b want 0/010/0",
                               ex_valid, alu_control, ex_reg_write);
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 0", stall); end
        tick();
        @(negedge clk);
        drive_fwd(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0);
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b010,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (alu_a !== 32'h55 || alu_b !== 32'h7 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL lu_mem_fwd: a=%h b=%h valid=%b want 55/7/1", alu_a, alu_b, ex_valid);
        end
    endtask

    task automatic test_flush_hazard();
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 32'h10, 3'b010,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        drive_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h1, 32'h2, 32'd0, 3'b001,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        flush = 1'b0;
        n_checks++;
        if (ex_valid !== 1'b0 || alu_control !== 3'b010 || ex_dest !== 5'd0) begin
            n_fail++; $display("FAIL flush_bubble: valid=%b ctrl=%b dest=%0d want 0/010/0",
                               ex_valid, alu_control, ex_dest);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive_id(1'b1, 5'd2, 5'd6, 5'd0, 32'h200, 32'h1, 32'h40, 3'b010,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // sw r6, 64(r2)
        tick();
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hABCD);
        #1;
        n_checks++;
        if (ex_write_data !== 32'hABCD) begin n_fail++; $display("FAIL st_data: got %h want abcd", ex_write_data); end
        n_checks++;
        if (alu_b !== 32'h40 || ex_mem_write !== 1'b1) begin
            n_fail++; $display("FAIL st_alu_b: b=%h mw=%b want 40/1", alu_b, ex_mem_write);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_id($urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                     5'($urandom_range(7, 0)), $urandom, $urandom, $urandom,
                     3'($urandom_range(7, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(2, 0) == 0, 1'($urandom), 1'($urandom));
            flush = ($urandom_range(7, 0) == 0);
            drive_fwd(1'($urandom), 5'($urandom_range(7, 0)), $urandom,
                      1'($urandom), 5'($urandom_range(7, 0)), $urandom);
            #1;
            n_checks++;
            if (stall !== m_stall()) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, m_stall());
            end
            n_checks++;
            if (alu_a !== m_a() || alu_b !== m_b() || ex_write_data !== m_wd()) begin
                n_fail++; $display("FAIL rnd_ops[%0d]: a=%h b=%h wd=%h want %h/%h/%h",
                                   i, alu_a, alu_b, ex_write_data, m_a(), m_b(), m_wd());
            end
            n_checks++;
            if ({alu_control, ex_dest, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !==
                {model.ctrl, model.dest, model.valid, model.rw, model.mr, model.mw, model.m2r}) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i,
                    {alu_control, ex_dest, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                    {model.ctrl, model.dest, model.valid, model.rw, model.mr, model.mw, model.m2r});
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        model = nop_ex();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b010,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_fwd_priority();
        test_reg0_imm();
        test_load_use();
        test_flush_hazard();
        test_store();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
